lsu_wb_stage: RTL and testbench
===============================

Name: lsu_wb_stage

Overview:
- Memory-access / writeback stage of the RV32 pipeline. Sits between EX and the register file write port.
- Accepts one instruction per cycle from EX. Non-memory results retire to the register file one cycle later.
- Loads and stores run a data-bus transaction; the stage stalls upstream until the transaction completes.
- Drives the register file write port (wen/wraddr/wrdata) from registers only.

Parameters:
- ADDR_W, 32, data-bus address width.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX presents an instruction
- ex_rd  in  5  destination register
- ex_rd_wen  in  1  instruction writes rd
- ex_is_load  in  1  load instruction
- ex_is_store  in  1  store instruction
- ex_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- ex_result  in  32  ALU result, or effective address for load/store
- ex_store_data  in  32  rs2 value for stores
- stall  out  1  EX must hold its outputs stable; the stage ignores ex_valid while high
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  store data, lane-aligned
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response valid; exactly one per granted request
- mem_rdata  in  32  read data
- wen  out  1  register file write enable
- wraddr  out  5  register file write address
- wrdata  out  32  register file write data
- access_err  out  1  one-cycle pulse on a misaligned access or illegal funct3

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - stall, mem_req, mem_we, wen and access_err = 0.
  - mem_addr, mem_be, mem_wdata, wraddr and wrdata = 0.
  - A bus response still in flight when reset asserts is dropped.
- FSM states: IDLE, REQ, WAIT. stall = (state != IDLE).
- Accept: the stage accepts an instruction when state == IDLE && ex_valid. ex_is_load takes priority if both ex_is_load and ex_is_store are set.
- Non-memory instruction:
  - Next cycle: wen = ex_rd_wen && (ex_rd != 0), wraddr = ex_rd, wrdata = ex_result.
  - wen is high for exactly one cycle.
- wen is never asserted with wraddr == 0. The register file forwards wrdata on an address match, so a write to x0 would corrupt reads of x0.
- Memory instruction, alignment check:
  - H/HU misaligned when addr[0] != 0.
  - W misaligned when addr[1:0] != 0.
  - Illegal funct3: loads 011/110/111; stores anything above 010.
  - On any of these: access_err pulses next cycle, no bus request, no writeback, state stays IDLE.
- Memory instruction, aligned:
  - IDLE -> REQ. mem_req = 1 from the next cycle.
  - mem_addr = {addr[31:2], 2'b00}.
  - All request outputs are held stable until mem_gnt.
- Store lane formatting:
  - SB: be = 0001 << addr[1:0], wdata = byte replicated x4.
  - SH: be = 0011 or 1100 by addr[1], wdata = halfword replicated x2.
  - SW: be = 1111.
- Loads: mem_we = 0, be formatted as for the matching store size.
- REQ state: when mem_req && mem_gnt, drop mem_req the next cycle and go REQ -> WAIT. A grant in the first request cycle is valid.
- WAIT state:
  - On mem_rvalid, go WAIT -> IDLE.
  - mem_rvalid outside WAIT is ignored. rvalid in the same cycle as gnt is not a completion.
- Load writeback, in the cycle after rvalid:
  - wrdata is the lane extracted by addr[1:0]: LB/LH sign-extended, LBU/LHU zero-extended, LW whole word.
  - wen = ex_rd_wen && rd != 0.
  - The bus access is still performed when rd == 0.
- Stores: no writeback; completion is signalled by rvalid.
- Latencies:
  - Non-memory: accept -> wen, 1 cycle.
  - Load: accept at T, req at T+1, gnt at G >= T+1, rvalid at R >= G+1, wen at R+1.
- Back-to-back:
  - stall is high from the cycle after accept until the cycle the FSM returns to IDLE.
  - The next instruction may be accepted in the same cycle a load's wen is asserted.

Test Plan:
- ALU op: ex_rd=5, ex_result=0x1234_5678, ex_rd_wen=1 -> next cycle wen=1, wraddr=5, wrdata=0x12345678; stall stays 0.
- ALU op to x0: ex_rd=0, ex_rd_wen=1 -> wen never asserts.
- LB addr 0x103, gnt 2 cycles later, rvalid 1 cycle after gnt, rdata=0x80AA_BBCC:
  - mem_req=1 with mem_addr=0x100, be=1000 until gnt.
  - wen with wrdata=0xFFFF_FF80.
  - stall high throughout, then low.
- LHU addr 0x202, rdata=0x8001_0000 -> wrdata=0x0000_8001. SH addr 0x202, data 0xABCD -> be=1100, wdata=0xABCD_ABCD, mem_we=1, no wen.
- LW addr 0x301 -> access_err pulse, no mem_req, no wen, stall 0. funct3=011 load -> access_err pulse.
- Reset in WAIT, with a late rvalid arriving after reset release -> state IDLE, no wen, stall 0.

Source files
------------

// File: rtl/lsu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_wb_stage
// Purpose  : RV32 memory-access / writeback stage: retires ALU results, runs
//            load/store bus transactions and drives the register-file port.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_wb_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [4:0]        ex_rd,
    input  logic              ex_rd_wen,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_result,
    input  logic [31:0]       ex_store_data,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              wen,
    output logic [4:0]        wraddr,
    output logic [31:0]       wrdata,
    output logic              access_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] c_SIZE_B = 2'b00;
    localparam logic [1:0] c_SIZE_H = 2'b01;
    localparam logic [1:0] c_SIZE_W = 2'b10;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic              r_wen;
    logic [4:0]        r_wraddr;
    logic [31:0]       r_wrdata;
    logic              r_access_err;

    // Context of the outstanding load, kept for the writeback cycle
    logic [2:0]        r_ld_funct3;
    logic [1:0]        r_ld_off;
    logic [4:0]        r_rd;
    logic              r_rd_wen;
    logic              r_is_load;

    logic              w_accept;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_mem;
    logic [1:0]        w_size;
    logic              w_illegal;
    logic              w_misaligned;
    logic              w_err;
    logic              w_mem_start;
    logic              w_granted;
    logic              w_done;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [ADDR_W-1:0] w_addr_aligned;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic [31:0]       w_ld_data;

    // ------------------------------------------------------------------
    // Instruction decode at the accept point
    // ------------------------------------------------------------------
    assign w_accept     = (r_state == S_IDLE) && ex_valid;
    assign w_is_load    = ex_is_load;
    assign w_is_store   = ex_is_store && !ex_is_load;
    assign w_is_mem     = w_is_load || w_is_store;
    assign w_size       = ex_funct3[1:0];
    assign w_illegal    = w_is_load ? ((ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11))
                                    : (ex_funct3 > 3'b010);
    assign w_misaligned = ((w_size == c_SIZE_H) && ex_result[0]) ||
                          ((w_size == c_SIZE_W) && (ex_result[1:0] != 2'b00));
    assign w_err        = w_is_mem && (w_illegal || w_misaligned);
    assign w_mem_start  = w_accept && w_is_mem && !w_err;

    assign w_addr_aligned = ADDR_W'({ex_result[31:2], 2'b00});
    assign w_granted      = (r_state == S_REQ) && r_mem_req && mem_gnt;
    assign w_done         = (r_state == S_WAIT) && mem_rvalid;

    // Byte-lane formatting shared by loads and stores
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = ex_store_data;
        case (w_size)
            c_SIZE_B: begin
                w_be    = 4'b0001 << ex_result[1:0];
                w_wdata = {4{ex_store_data[7:0]}};
            end
            c_SIZE_H: begin
                w_be    = ex_result[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{ex_store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = ex_store_data;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        w_ld_byte = mem_rdata[7:0];
        case (r_ld_off)
            2'd0:    w_ld_byte = mem_rdata[7:0];
            2'd1:    w_ld_byte = mem_rdata[15:8];
            2'd2:    w_ld_byte = mem_rdata[23:16];
            default: w_ld_byte = mem_rdata[31:24];
        endcase
        w_ld_half = r_ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_ld_funct3)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld_data = {24'd0, w_ld_byte};
            3'b101:  w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_mem_start) w_state_nxt = S_REQ;
            S_REQ:  if (w_granted)   w_state_nxt = S_WAIT;
            S_WAIT: if (w_done)      w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus request, writeback and error registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= 4'd0;
            r_mem_wdata  <= 32'd0;
            r_wen        <= 1'b0;
            r_wraddr     <= 5'd0;
            r_wrdata     <= 32'd0;
            r_access_err <= 1'b0;
            r_ld_funct3  <= 3'd0;
            r_ld_off     <= 2'd0;
            r_rd         <= 5'd0;
            r_rd_wen     <= 1'b0;
            r_is_load    <= 1'b0;
        end else begin
            r_wen        <= 1'b0;
            r_access_err <= 1'b0;

            if (w_accept) begin
                if (!w_is_mem) begin
                    r_wen    <= ex_rd_wen && (ex_rd != 5'd0);
                    r_wraddr <= ex_rd;
                    r_wrdata <= ex_result;
                end else if (w_err) begin
                    r_access_err <= 1'b1;
                end else begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= w_is_store;
                    r_mem_addr  <= w_addr_aligned;
                    r_mem_be    <= w_be;
                    r_mem_wdata <= w_wdata;
                    r_ld_funct3 <= ex_funct3;
                    r_ld_off    <= ex_result[1:0];
                    r_rd        <= ex_rd;
                    r_rd_wen    <= ex_rd_wen && (ex_rd != 5'd0);
                    r_is_load   <= w_is_load;
                end
            end

            if (w_granted) begin
                r_mem_req <= 1'b0;
            end

            // Writes to x0 were already filtered into r_rd_wen at accept
            if (w_done && r_is_load) begin
                r_wen    <= r_rd_wen;
                r_wraddr <= r_rd;
                r_wrdata <= w_ld_data;
            end
        end
    end

    assign stall      = (r_state != S_IDLE);
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;
    assign wen        = r_wen;
    assign wraddr     = r_wraddr;
    assign wrdata     = r_wrdata;
    assign access_err = r_access_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_wb_stage
// Purpose  : Self-checking bench for lsu_wb_stage: transaction-level model
//            plus directed vectors with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_wb_stage;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_valid, ex_rd_wen, ex_is_load, ex_is_store;
    logic [4:0]        ex_rd;
    logic [2:0]        ex_funct3;
    logic [31:0]       ex_result, ex_store_data;
    logic              stall, mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              wen, access_err;
    logic [4:0]        wraddr;
    logic [31:0]       wrdata;

    lsu_wb_stage #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wen(wen), .wraddr(wraddr), .wrdata(wrdata), .access_err(access_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle
    logic        chk_en = 1'b0;
    logic        m_stall = 1'b0, m_req = 1'b0, m_we = 1'b0, m_wen = 1'b0, m_err = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_wrdata = '0;
    logic [3:0]  m_be = '0;
    logic [4:0]  m_wraddr = '0;

    // Last request seen on the bus
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic [3:0]  cap_be = '0;
    logic        cap_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Access size in bytes and the lowest byte lane the access occupies
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic int lane(input logic [2:0] f3, input logic [31:0] a);
        int n = nbytes(f3);
        return (int'(a[1:0]) / n) * n;
    endfunction

    function automatic logic f_err(input logic ld, input logic [2:0] f3, input logic [31:0] a);
        logic legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
        if (!legal) return 1'b1;
        return (int'(a[1:0]) % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [31:0] a);
        int n = nbytes(f3);
        return 4'(((1 << n) - 1) << lane(f3, a));
    endfunction

    function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        int n = nbytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] f_ld(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
        int n = nbytes(f3);
        logic [31:0] v = rd >> (8 * lane(f3, a));
        logic [31:0] mask;
        if (n < 4) begin
            mask = (32'd1 << (8 * n)) - 32'd1;
            v = v & mask;
            if (!f3[2] && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'd0, stall}, {31'd0, m_stall});
            chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
            chk("wen", {31'd0, wen}, {31'd0, m_wen});
            chk("access_err", {31'd0, access_err}, {31'd0, m_err});
            if (m_req) begin
                chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_be", {28'd0, mem_be}, {28'd0, m_be});
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            if (m_wen) begin
                chk("wraddr", {27'd0, wraddr}, {27'd0, m_wraddr});
                chk("wrdata", wrdata, m_wrdata);
            end
            if (wen === 1'b1) chk("wen_to_x0", {31'd0, wraddr == 5'd0}, 32'd0);
            if (mem_req === 1'b1) begin
                cap_addr  <= mem_addr;
                cap_be    <= mem_be;
                cap_wdata <= mem_wdata;
                cap_we    <= mem_we;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        m_wen = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic do_alu(input logic [4:0] rd, input logic [31:0] res, input logic rdwen);
        ex_valid = 1'b1; ex_rd = rd; ex_rd_wen = rdwen; ex_is_load = 1'b0; ex_is_store = 1'b0;
        ex_funct3 = 3'd0; ex_result = res; ex_store_data = 32'd0;
        tick();
        ex_valid = 1'b0;
        m_wen = rdwen && (rd != 5'd0); m_wraddr = rd; m_wrdata = res;
    endtask

    // EX holds the instruction (ex_valid included) until stall drops.
    task automatic do_mem(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] rd, input logic rdwen,
                          input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                          input logic rv_with_gnt, input logic rst_in_wait);
        ex_valid = 1'b1; ex_rd = rd; ex_rd_wen = rdwen; ex_is_load = ld; ex_is_store = st;
        ex_funct3 = f3; ex_result = a; ex_store_data = sd;
        tick();
        if (f_err(ld, f3, a)) begin
            m_err = 1'b1;
            ex_valid = 1'b0;
            return;
        end
        m_stall = 1'b1; m_req = 1'b1; m_we = !ld;
        m_addr = {a[31:2], 2'b00}; m_be = f_be(f3, a); m_wdata = f_wdata(f3, sd);
        repeat (gnt_wait) tick();
        mem_gnt = 1'b1; mem_rvalid = rv_with_gnt; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; m_req = 1'b0;
        if (rst_in_wait) begin
            #2 rst_n = 1'b0;
            m_stall = 1'b0; ex_valid = 1'b0;
            #1;
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_wrdata", wrdata, 32'd0);
            tick(); tick();
            rst_n = 1'b1;
            tick();
            mem_rvalid = 1'b1; mem_rdata = rdata;
            tick();
            mem_rvalid = 1'b0;
            tick();
            return;
        end
        repeat (rv_wait - 1) tick();
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0; ex_valid = 1'b0; m_stall = 1'b0;
        if (ld) begin
            m_wen = rdwen && (rd != 5'd0); m_wraddr = rd; m_wrdata = f_ld(f3, a, rdata);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_rd = '0; ex_rd_wen = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        ex_funct3 = '0; ex_result = '0; ex_store_data = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        repeat (2) @(negedge clk);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_be", {28'd0, mem_be}, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        chk("reset_wen", {31'd0, wen}, 32'd0);
        chk("reset_wraddr", {27'd0, wraddr}, 32'd0);
        chk("reset_wrdata", wrdata, 32'd0);
        chk("reset_access_err", {31'd0, access_err}, 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // ALU retire, x0 suppression, rd_wen low
        do_alu(5'd5, 32'h1234_5678, 1'b1);
        @(negedge clk);
        chk("alu_wrdata", wrdata, 32'h1234_5678);
        chk("alu_wraddr", {27'd0, wraddr}, 32'd5);
        do_alu(5'd0, 32'hCAFE_F00D, 1'b1);
        do_alu(5'd6, 32'h0000_0001, 1'b0);

        // LB 0x103, grant after two request cycles
        do_mem(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 5'd7, 1'b1, 2, 1, 32'h80AA_BBCC, 1'b0, 1'b0);
        @(negedge clk);
        chk("lb_wrdata", wrdata, 32'hFFFF_FF80);
        chk("lb_addr", cap_addr, 32'h100);
        chk("lb_be", {28'd0, cap_be}, 32'b1000);

        // LHU with grant in the first request cycle
        do_mem(1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 5'd8, 1'b1, 0, 1, 32'h8001_0000, 1'b0, 1'b0);
        @(negedge clk);
        chk("lhu_wrdata", wrdata, 32'h0000_8001);

        // SH with a stray rvalid alongside the grant
        do_mem(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd9, 1'b1, 1, 2, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("sh_be", {28'd0, cap_be}, 32'b1100);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_we", {31'd0, cap_we}, 32'd1);

        // Load+store flags together act as LW; ALU accepted in the load's wen cycle
        do_mem(1'b1, 1'b1, 3'b010, 32'h40, 32'h5555_5555, 5'd9, 1'b1, 0, 1, 32'h89AB_CDEF, 1'b0, 1'b0);
        do_alu(5'd10, 32'h0000_0077, 1'b1);
        @(negedge clk);
        chk("b2b_wraddr", {27'd0, wraddr}, 32'd10);

        do_mem(1'b0, 1'b1, 3'b000, 32'h1, 32'h0000_0055, 5'd0, 1'b0, 1, 1, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sb_be", {28'd0, cap_be}, 32'b0010);
        chk("sb_wdata", cap_wdata, 32'h5555_5555);

        do_mem(1'b1, 1'b0, 3'b000, 32'h2, 32'd0, 5'd0, 1'b1, 0, 1, 32'h00FF_0000, 1'b0, 1'b0);
        do_mem(1'b1, 1'b0, 3'b100, 32'h3, 32'd0, 5'd12, 1'b0, 1, 3, 32'hF000_0000, 1'b0, 1'b0);
        do_mem(1'b1, 1'b0, 3'b001, 32'h6, 32'd0, 5'd13, 1'b1, 0, 1, 32'hC3A5_0000, 1'b0, 1'b0);
        @(negedge clk);
        chk("lh_wrdata", wrdata, 32'hFFFF_C3A5);

        // Misaligned and illegal accesses
        do_mem(1'b1, 1'b0, 3'b010, 32'h301, 32'd0, 5'd14, 1'b1, 0, 1, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lw_mis_err", {31'd0, access_err}, 32'd1);
        do_mem(1'b1, 1'b0, 3'b011, 32'h0, 32'd0, 5'd14, 1'b1, 0, 1, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ld_f3_011_err", {31'd0, access_err}, 32'd1);
        do_mem(1'b0, 1'b1, 3'b100, 32'h0, 32'd0, 5'd0, 1'b0, 0, 1, 32'd0, 1'b0, 1'b0);
        do_mem(1'b0, 1'b1, 3'b001, 32'h3, 32'd0, 5'd0, 1'b0, 0, 1, 32'd0, 1'b0, 1'b0);
        tick();

        // Reset while waiting for the response; late rvalid must be dropped
        do_mem(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 5'd11, 1'b1, 1, 1, 32'h1111_2222, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        chk("post_rst_wen", {31'd0, wen}, 32'd0);
        do_alu(5'd3, 32'h0000_0033, 1'b1);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
